// File: rtl/pry_pkg.sv
// Shared helpers for the priority/arbitration blocks: one-hot encoding,
// the strictly-higher mask used for round-robin rotation, and the arbiter state type.
package pry_pkg;

   localparam int PRY_MAX_W = 64;
   localparam int PRY_IDX_W = 6;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } pry_state_t;

   function automatic logic [PRY_IDX_W-1:0] oht2bin(input logic [PRY_MAX_W-1:0] oht);
      logic [PRY_IDX_W-1:0] idx;
      idx = {PRY_IDX_W{1'b0}};
      for (int i = 0; i < PRY_MAX_W; i++) begin
         if (oht[i]) begin
            idx = idx | i[PRY_IDX_W-1:0];
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   // Bits strictly above the set bit; a grant at the top bit yields zero in the used width.
   function automatic logic [PRY_MAX_W-1:0] mask_above(input logic [PRY_MAX_W-1:0] oht);
      return ~((oht << 1) - 64'd1);
   endfunction

endpackage

// File: rtl/pry2oht_base.sv
// Priority-to-one-hot: keeps only the lowest set request bit.
// IMPLEMENTATION selects the structure: 0 adder, 1 loop, 2 vector.
module pry2oht_base #(
   parameter int WIDTH          = 8,
   parameter int IMPLEMENTATION = 0
) (
   input  logic [WIDTH-1:0] req,
   output logic [WIDTH-1:0] oht,
   output logic             vld
);

   assign vld = |req;

   generate
      case (IMPLEMENTATION)
         1: begin : g_loop
            // Walk from bit 0 and stop at the first request.
            always_comb begin
               logic found_s;
               found_s = 1'b0;
               oht     = {WIDTH{1'b0}};
               for (int i = 0; i < WIDTH; i++) begin
                  if (req[i] && !found_s) begin
                     oht[i]  = 1'b1;
                     found_s = 1'b1;
                  end else begin
                     oht[i]  = 1'b0;
                  end
               end
            end
         end
         2: begin : g_vector
            assign oht[0] = req[0];
            for (genvar i = 1; i < WIDTH; i++) begin : g_bit
               assign oht[i] = req[i] & ~(|req[i-1:0]);
            end
         end
         default: begin : g_adder
            assign oht = req & (~req + WIDTH'(1));
         end
      endcase
   endgenerate

endmodule

// File: rtl/pry_arb_rr.sv
// Registered round-robin arbiter with valid/ready grant handshake.
// Optional grant lock enabled by defining PRY_ARB_RR_LOCK_EN.
module pry_arb_rr
   import pry_pkg::*;
#(
   parameter  int WIDTH          = 8,
   parameter  int IMPLEMENTATION = 0,
   localparam int WIDTH_LOG      = $clog2(WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     req,
   output logic                 grt_vld,
   input  logic                 grt_rdy,
   output logic [WIDTH-1:0]     grt_oht,
   output logic [WIDTH_LOG-1:0] grt_idx
`ifdef PRY_ARB_RR_LOCK_EN
   ,
   input  logic                 grt_lck
`endif
);

   pry_state_t              state_r;
   logic [WIDTH-1:0]        mask_r;
   logic [WIDTH-1:0]        m_oht_s;
   logic [WIDTH-1:0]        u_oht_s;
   logic                    m_vld_s;
   logic                    u_vld_s;
   logic [WIDTH-1:0]        cand_s;
   logic                    cand_vld_s;
   logic [PRY_MAX_W-1:0]    cand_ext_s;
   logic [PRY_MAX_W-1:0]    mask_full_s;
   logic [PRY_IDX_W-1:0]    idx_full_s;
   logic                    xfer_s;
   logic                    lock_s;
   logic                    unused_s;

   pry2oht_base #(.WIDTH(WIDTH), .IMPLEMENTATION(IMPLEMENTATION)) u_masked (
      .req (req & mask_r),
      .oht (m_oht_s),
      .vld (m_vld_s)
   );

   pry2oht_base #(.WIDTH(WIDTH), .IMPLEMENTATION(IMPLEMENTATION)) u_unmasked (
      .req (req),
      .oht (u_oht_s),
      .vld (u_vld_s)
   );

   assign cand_s     = m_vld_s ? m_oht_s : u_oht_s;
   assign cand_vld_s = u_vld_s;
   assign xfer_s     = grt_vld && grt_rdy;

`ifdef PRY_ARB_RR_LOCK_EN
   assign lock_s = xfer_s && grt_lck;
`else
   assign lock_s = 1'b0;
`endif

   // Widen the candidate to the helper width and derive its index and next mask.
   always_comb begin
      cand_ext_s               = {PRY_MAX_W{1'b0}};
      cand_ext_s[WIDTH-1:0]    = cand_s;
      idx_full_s               = oht2bin(cand_ext_s);
      mask_full_s              = mask_above(cand_ext_s);
   end

   assign unused_s = ^(mask_full_s >> WIDTH) ^ ^(idx_full_s >> WIDTH_LOG);

   // Grant state machine; all outputs are registered and held until accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         grt_vld <= 1'b0;
         grt_oht <= {WIDTH{1'b0}};
         grt_idx <= {WIDTH_LOG{1'b0}};
         mask_r  <= {WIDTH{1'b1}};
      end else begin
         case (state_r)
            IDLE: begin
               if (cand_vld_s) begin
                  state_r <= GRANT;
                  grt_vld <= 1'b1;
                  grt_oht <= cand_s;
                  grt_idx <= idx_full_s[WIDTH_LOG-1:0];
                  mask_r  <= mask_full_s[WIDTH-1:0];
               end else begin
                  state_r <= IDLE;
               end
            end
            GRANT: begin
               if (!xfer_s || lock_s) begin
                  state_r <= GRANT;
               end else if (cand_vld_s) begin
                  grt_oht <= cand_s;
                  grt_idx <= idx_full_s[WIDTH_LOG-1:0];
                  mask_r  <= mask_full_s[WIDTH-1:0];
               end else begin
                  state_r <= IDLE;
                  grt_vld <= 1'b0;
                  grt_oht <= {WIDTH{1'b0}};
                  grt_idx <= {WIDTH_LOG{1'b0}};
               end
            end
            default: begin
               state_r <= IDLE;
               grt_vld <= 1'b0;
               grt_oht <= {WIDTH{1'b0}};
               grt_idx <= {WIDTH_LOG{1'b0}};
               mask_r  <= {WIDTH{1'b1}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pry_arb_rr.sv
// Directed bench for pry_arb_rr (WIDTH=8): vector table plus reset and lock sequences.
module tb_pry_arb_rr;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic       grt_rdy;
   logic       grt_vld;
   logic [7:0] grt_oht;
   logic [2:0] grt_idx;
`ifdef PRY_ARB_RR_LOCK_EN
   logic       grt_lck;
`endif

   int n_cmp;
   int n_bad;

   typedef struct {
      logic       rst_n;
      logic [7:0] req;
      logic       rdy;
      logic       vld;
      logic [7:0] oht;
      logic [2:0] idx;
   } vec_t;

   vec_t tbl [20];

   pry_arb_rr #(.WIDTH(8), .IMPLEMENTATION(0)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .grt_vld (grt_vld),
      .grt_rdy (grt_rdy),
      .grt_oht (grt_oht),
      .grt_idx (grt_idx)
`ifdef PRY_ARB_RR_LOCK_EN
      ,
      .grt_lck (grt_lck)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string tag, input logic vld, input logic [7:0] oht,
                          input logic [2:0] idx);
      chk({tag, ".vld"}, 32'(grt_vld), 32'(vld));
      chk({tag, ".oht"}, 32'(grt_oht), 32'(oht));
      chk({tag, ".idx"}, 32'(grt_idx), 32'(idx));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      rst_n   = 1'b0;
      req     = 8'h00;
      grt_rdy = 1'b0;
`ifdef PRY_ARB_RR_LOCK_EN
      grt_lck = 1'b0;
`endif

      //          rst   req    rdy   vld   oht    idx
      tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0};
      tbl[1]  = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0};
      tbl[2]  = '{1'b1, 8'h05, 1'b1, 1'b1, 8'h01, 3'd0};
      tbl[3]  = '{1'b1, 8'h05, 1'b1, 1'b1, 8'h04, 3'd2};
      tbl[4]  = '{1'b1, 8'h05, 1'b1, 1'b1, 8'h01, 3'd0};
      tbl[5]  = '{1'b1, 8'h05, 1'b1, 1'b1, 8'h04, 3'd2};
      tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0};
      tbl[7]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 8'h01, 3'd0};
      tbl[8]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 8'h01, 3'd0};
      tbl[9]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 8'h01, 3'd0};
      tbl[10] = '{1'b1, 8'hFF, 1'b0, 1'b1, 8'h01, 3'd0};
      tbl[11] = '{1'b1, 8'hFF, 1'b0, 1'b1, 8'h01, 3'd0};
      tbl[12] = '{1'b1, 8'h80, 1'b0, 1'b1, 8'h01, 3'd0};
      tbl[13] = '{1'b1, 8'h80, 1'b1, 1'b1, 8'h80, 3'd7};
      tbl[14] = '{1'b1, 8'h80, 1'b1, 1'b1, 8'h80, 3'd7};
      tbl[15] = '{1'b1, 8'h81, 1'b0, 1'b1, 8'h80, 3'd7};
      tbl[16] = '{1'b1, 8'h81, 1'b1, 1'b1, 8'h01, 3'd0};
      tbl[17] = '{1'b1, 8'h81, 1'b1, 1'b1, 8'h80, 3'd7};
      tbl[18] = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0};
      tbl[19] = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0};

      #2;
      for (int i = 0; i < 20; i++) begin
         rst_n   = tbl[i].rst_n;
         req     = tbl[i].req;
         grt_rdy = tbl[i].rdy;
         tick();
         chk_out($sformatf("vec%0d", i), tbl[i].vld, tbl[i].oht, tbl[i].idx);
      end

      // Asynchronous reset while a grant is pending clears outputs before the next edge.
      rst_n   = 1'b0;
      tick();
      rst_n   = 1'b1;
      req     = 8'h20;
      grt_rdy = 1'b0;
      tick();
      chk_out("rst_pre", 1'b1, 8'h20, 3'd5);
      rst_n = 1'b0;
      #2;
      chk_out("rst_async", 1'b0, 8'h00, 3'd0);
      rst_n = 1'b1;
      req   = 8'h24;
      tick();
      chk_out("rst_post", 1'b1, 8'h04, 3'd2);

`ifdef PRY_ARB_RR_LOCK_EN
      // Locked transfers keep the same grant; releasing the lock rotates onward.
      rst_n = 1'b0;
      tick();
      rst_n   = 1'b1;
      req     = 8'h08;
      grt_rdy = 1'b0;
      tick();
      chk_out("lck_pre", 1'b1, 8'h08, 3'd3);
      req     = 8'h18;
      grt_lck = 1'b1;
      grt_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out($sformatf("lck_hold%0d", i), 1'b1, 8'h08, 3'd3);
      end
      grt_lck = 1'b0;
      tick();
      chk_out("lck_rel", 1'b1, 8'h10, 3'd4);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
